// File: rtl/tt_um_happy_new_year_2026.sv
// ============================================================================
// Module      : tt_um_happy_new_year_2026
// Description : Tiny Tapeout tile scrolling "HAPPY NEW YEAR 2026" on one
//               seven-segment digit, with pause/fast/manual-step controls.
//               Optional macro HNY_INVERT_EN enables segment inversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_happy_new_year_2026 #(
    parameter int STEP_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int               CNT_W       = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM_NORMAL = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_FAST   = CNT_W'(STEP_CYCLES / 4 - 1);
    localparam logic [4:0]       LAST_IDX    = 5'd19;

    // The harness name is kept, but the pin is an active-high reset.
    logic rst;
    assign rst = rst_n;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [1:0]       sync_q;
    logic             edge_q;
    logic             wrap_q, wrap_d;
    logic [7:0]       uo_q, uo_d;
    logic [7:0]       uio_q, uio_d;

    logic [CNT_W-1:0] term;
    logic             pause;
    logic             man_edge;
    logic             advance;
    logic [6:0]       glyph;
    logic [6:0]       seg;

    assign pause = ui_in[0];

    always_comb begin
        term     = ui_in[1] ? TERM_FAST : TERM_NORMAL;
        man_edge = sync_q[1] & ~edge_q;
        advance  = 1'b0;
        cnt_d    = cnt_q;

        if (pause) begin
            advance = man_edge;
        end else if (cnt_q >= term) begin
            advance = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;
        end
        wrap_d = advance && (idx_q == LAST_IDX);
    end

    always_comb begin
        glyph = 7'h00;
        case (idx_q)
            5'd0:    glyph = 7'h76;  // H
            5'd1:    glyph = 7'h77;  // A
            5'd2:    glyph = 7'h73;  // P
            5'd3:    glyph = 7'h73;  // P
            5'd4:    glyph = 7'h6E;  // Y
            5'd6:    glyph = 7'h54;  // n
            5'd7:    glyph = 7'h79;  // E
            5'd8:    glyph = 7'h3E;  // W
            5'd10:   glyph = 7'h6E;  // Y
            5'd11:   glyph = 7'h79;  // E
            5'd12:   glyph = 7'h77;  // A
            5'd13:   glyph = 7'h50;  // r
            5'd15:   glyph = 7'h5B;  // 2
            5'd16:   glyph = 7'h3F;  // 0
            5'd17:   glyph = 7'h5B;  // 2
            5'd18:   glyph = 7'h7D;  // 6
            default: glyph = 7'h00;  // blanks
        endcase
    end

`ifdef HNY_INVERT_EN
    assign seg = glyph ^ {7{ui_in[3]}};
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
    assign seg = glyph;
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};
`endif

    // Outputs follow the index one cycle later, so the wrap flag is held
    // for one cycle to line up with the display of index 0.
    always_comb begin
        uo_d  = {(idx_q == LAST_IDX), seg};
        uio_d = {2'b00, wrap_q, idx_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            sync_q <= '0;
            edge_q <= 1'b0;
            wrap_q <= 1'b0;
            uo_q   <= '0;
            uio_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sync_q <= {sync_q[0], ui_in[2]};
            edge_q <= sync_q[1];
            wrap_q <= wrap_d;
            uo_q   <= uo_d;
            uio_q  <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = 8'h3F;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_happy_new_year_2026.sv
// ============================================================================
// Module      : tb_tt_um_happy_new_year_2026
// Description : Directed self-checking bench for the greeting scroller tile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_happy_new_year_2026;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] rom [20] = '{7'h76, 7'h77, 7'h73, 7'h73, 7'h6E, 7'h00, 7'h54,
                             7'h79, 7'h3E, 7'h00, 7'h6E, 7'h79, 7'h77, 7'h50,
                             7'h00, 7'h5B, 7'h3F, 7'h5B, 7'h7D, 7'h00};

    tt_um_happy_new_year_2026 #(
        .STEP_CYCLES(8)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] idx_of(input logic [7:0] v);
        return {3'b000, v[4:0]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b1;
        tick(2);
        check_eq("rst_uo", uo_out, 8'h00);
        check_eq("rst_uio", uio_out, 8'h00);
        rst_n = 1'b0;
    endtask

    initial begin
        int e;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        logic [7:0] inv0;
        logic [7:0] inv19;

        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'hA5;

        // Reset, first step and one full pass of the message including wrap
        do_reset();
        check_eq("uio_oe", uio_oe, 8'h3F);
        for (int k = 1; k <= 161; k++) begin
            tick(1);
            e       = ((k - 1) / 8) % 20;
            exp_uo  = {(e == 19), rom[e]};
            exp_uio = {2'b00, (k == 161), 5'(e)};
            if (k == 1) begin
                check_eq("first_uo", uo_out, 8'h76);
                check_eq("first_uio", uio_out, 8'h00);
            end else if (k == 9) begin
                check_eq("step1_uo", uo_out, 8'h77);
                check_eq("step1_uio", uio_out, 8'h01);
            end
            check_eq("msg_uo", uo_out, exp_uo);
            check_eq("msg_uio", uio_out, exp_uio);
        end

        // Pause freezes the index
        ui_in = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick(10);
            check_eq("pause_idx", uio_out, 8'h00);
            check_eq("pause_uo", uo_out, 8'h76);
        end

        // Three manual edges while paused
        for (int p = 0; p < 3; p++) begin
            ui_in = 8'h05;
            tick(5);
            check_eq("man_idx", idx_of(uio_out), 8'(p + 1));
            ui_in = 8'h01;
            tick(5);
        end
        check_eq("man_uo", uo_out, 8'h73);

        // Held-high level gives exactly one step
        ui_in = 8'h05;
        tick(4);
        check_eq("hold_first", idx_of(uio_out), 8'd4);
        tick(20);
        check_eq("hold_idx", idx_of(uio_out), 8'd4);
        check_eq("hold_uo", uo_out, 8'h6E);
        ui_in = 8'h01;
        tick(5);
        check_eq("hold_rel", idx_of(uio_out), 8'd4);

        // Unpause with a manual edge: edge ignored, prescaler resumes at count 1
        ui_in = 8'h04;
        tick(4);
        check_eq("unp_edge", idx_of(uio_out), 8'd4);
        tick(3);
        check_eq("unp_pre", idx_of(uio_out), 8'd4);
        tick(1);
        check_eq("unp_step", idx_of(uio_out), 8'd5);
        check_eq("unp_uo", uo_out, 8'h00);

        // Count reaches 5, then fast mode forces a step next cycle
        tick(4);
        check_eq("fast_pre", idx_of(uio_out), 8'd5);
        ui_in = 8'h02;
        tick(1);
        check_eq("fast_sw0", idx_of(uio_out), 8'd5);
        tick(1);
        check_eq("fast_sw1", idx_of(uio_out), 8'd6);
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            check_eq("fast_hold", idx_of(uio_out), 8'(5 + j));
            tick(1);
            check_eq("fast_step", idx_of(uio_out), 8'(6 + j));
        end

        // Invert control at index 0 and index 19
`ifdef HNY_INVERT_EN
        inv0  = 8'h09;
        inv19 = 8'hFF;
`else
        inv0  = 8'h76;
        inv19 = 8'h80;
`endif
        ui_in = 8'h00;
        do_reset();
        ui_in = 8'h08;
        tick(1);
        check_eq("inv_idx0", uo_out, inv0);
        tick(152);
        check_eq("inv_idx19_uio", uio_out, 8'd19);
        check_eq("inv_idx19", uo_out, inv19);

        // Reset in the middle of the message
        ui_in = 8'h00;
        do_reset();
        tick(57);
        check_eq("mid_idx", uio_out, 8'd7);
        check_eq("mid_uo", uo_out, 8'h79);
        rst_n = 1'b1;
        tick(1);
        check_eq("mid_rst_uo", uo_out, 8'h00);
        check_eq("mid_rst_uio", uio_out, 8'h00);
        rst_n = 1'b0;
        tick(1);
        check_eq("restart_uo", uo_out, 8'h76);
        check_eq("restart_uio", uio_out, 8'h00);
        tick(8);
        check_eq("restart_step_uo", uo_out, 8'h77);
        check_eq("restart_step_uio", uio_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_um_happy_new_year_2026.md
# tt_um_happy_new_year_2026

Tiny Tapeout user tile that scrolls the greeting "HAPPY NEW YEAR 2026" one character at a time on a single seven-segment display. The block is the top-level user module inside the Tiny Tapeout harness and uses the standard tile pinout. A parameterised prescaler sets the step rate. Dedicated inputs select pause, fast mode, manual stepping and polarity; the bidirectional pins export the character index and a wrap pulse.

## Interface
- STEP_CYCLES, default 10_000_000: clock cycles per character in normal mode. Must be at least 4 and a multiple of 4.
- clk  input  1  single system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-high reset. The port keeps the harness name, but a value of 1 resets the block.
- ena  input  1  harness enable; ignored.
- ui_in  input  8  controls:
  - [0] pause
  - [1] fast mode
  - [2] manual step
  - [3] invert
  - [7:4] unused
- uo_out  output  8  display: [6:0] segments a..g, [7] decimal point.
- uio_in  input  8  ignored.
- uio_out  output  8  status: [4:0] character index, [5] wrap pulse, [7:6] always 0.
- uio_oe  output  8  constant 8'h3F.

## Operation
- **Message ROM.** 20 entries, index 0..19, in this order: H A P P Y _ n E W _ Y E A r _ 2 0 2 6 _. The character "_" means blank.
- **Glyphs.** Bit0 = segment a … bit6 = segment g.
  - H=0x76, A=0x77, P=0x73, Y=0x6E, n=0x54, E=0x79
  - W=0x3E (U shape), r=0x50, 2=0x5B, 0=0x3F, 6=0x7D, blank=0x00
- **Prescaler.**
  - Terminal count is STEP_CYCLES-1 in normal mode and STEP_CYCLES/4-1 when ui_in[1]=1.
  - The compare is "count >= terminal". Switching to fast mode while the count is above the new terminal therefore causes a step on the next cycle.
  - On terminal: index advances by 1, wrapping from 19 to 0, and the count clears to 0.
- **Pause (ui_in[0]=1).** The prescaler count and the index both hold.
- **Manual step.**
  - ui_in[2] passes through a 2-flop synchroniser, then a registered edge detector.
  - Each rising edge advances the index by exactly one, and only while paused.
  - Edges are ignored when not paused. A held high level does not repeat.
- **Wrap pulse.** uio_out[5]=1 for exactly one cycle after any 19→0 transition, whether caused by the prescaler or a manual step.
- **Decimal point.** uo_out[7]=1 exactly while index==19.
- **Invert.** When HNY_INVERT_EN is defined and ui_in[3]=1, uo_out[6:0] = glyph XOR 0x7F. uo_out[7] is never inverted.
- **Unused signals.** ui_in[7:4], uio_in and ena have no effect.

## Timing
- **Reset values.** While rst_n=1 at a clock edge:
  - index = 0, prescaler = 0, synchroniser/edge flops = 0
  - uo_out = 0x00
  - uio_out = 0x00
- **Output registers.** uo_out and uio_out are registered from the current index. Each output changes one cycle after the index changes.
  - First cycle after reset release: uo_out = 0x76, uio_out = 0x00.
- **Step period.** Normal mode: the index changes every STEP_CYCLES cycles; the first step is STEP_CYCLES cycles after reset release.
- **Manual-step latency.** The index advances 3 cycles after ui_in[2] rises: 2 synchroniser flops plus the edge register.
- **Simultaneous events.**
  - Prescaler terminal and manual edge in the same cycle: impossible, because the prescaler is frozen while paused.
  - Pause asserted on the terminal cycle: the step is suppressed.
- **Reset mid-operation.** Reset overrides everything: the next cycle shows all reset values, regardless of index or prescaler state.

## Configuration
- Macro HNY_INVERT_EN.
  - Defined: ui_in[3]=1 inverts segments [6:0] as described above, for common-anode displays.
  - Undefined: ui_in[3] is ignored; segments are always active-high and no invert logic is synthesised.

## Test plan
All scenarios use STEP_CYCLES=8.
- **Reset and first step.** Hold rst_n=1 for 2 cycles, then release with ui_in=0.
  - Next cycle: uo_out=0x76, uio_out=0x00.
  - After 8 more cycles: uio_out[4:0]=1, uo_out=0x77.
- **Full message.** Run 160 cycles.
  - Glyph sequence matches the ROM.
  - uo_out[7]=1 only at index 19.
  - uio_out[5] pulses high for one cycle at the 19→0 wrap, then uo_out returns to 0x76.
- **Pause and manual step.**
  - ui_in[0]=1: the index is frozen for 50 cycles.
  - Three separate rising edges on ui_in[2] advance the index by exactly 3.
  - Holding ui_in[2] high for 20 cycles adds no further steps.
  - With ui_in[0]=0, an ui_in[2] edge does not advance the index outside the normal prescaler schedule.
- **Fast mode.** ui_in[1]=1: the index advances every 2 cycles.
  - Switching to fast mode while the count is at 5: a step occurs on the next cycle.
- **Invert.**
  - With HNY_INVERT_EN defined, ui_in[3]=1 at index 0: uo_out=0x09; at index 19: uo_out=0xFF.
  - Without the macro: index 0 gives uo_out=0x76; index 19 gives 0x80.
- **Reset mid-message.** Assert rst_n=1 at index 7.
  - Next cycle: uo_out=0x00, uio_out=0x00.
  - After release: the sequence restarts at H.
